// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the long-latency producer scoreboard: per-entry state
// encoding, entry record and the entry state transition function.
package hazard_scoreboard_pkg;

    localparam int unsigned SB_RD_W = 5;

    typedef enum logic [1:0] {
        SB_FREE = 2'd0,
        SB_PEND = 2'd1,
        SB_CMT  = 2'd2,
        SB_KILL = 2'd3
    } sb_state_e;

    typedef struct packed {
        sb_state_e          state;
        logic [SB_RD_W-1:0] rd;
    } sb_entry_t;

    // Completion outranks commit/flush; commit outranks flush on a PEND entry.
    function automatic sb_state_e sb_next_state(input sb_state_e cur,
                                                input logic      alloc,
                                                input logic      commit,
                                                input logic      flush,
                                                input logic      cpl);
        sb_state_e nxt;
        nxt = cur;
        unique case (cur)
            SB_FREE: if (alloc) nxt = SB_PEND;
            SB_PEND: begin
                if (cpl)         nxt = SB_FREE;
                else if (commit) nxt = SB_CMT;
                else if (flush)  nxt = SB_KILL;
            end
            SB_CMT,
            SB_KILL: if (cpl) nxt = SB_FREE;
            default: nxt = SB_FREE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: state FSM, destination register and the busy
// comparisons against the decode-stage operands. Honours HAZARD_SB_CPL_BYPASS_EN.
module hazard_sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned TAG_W      = 2,
    parameter int unsigned IDX        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc,
    input  logic [REG_ADDR_W-1:0] alloc_rd,
    input  logic                  commit_valid,
    input  logic [TAG_W-1:0]      commit_tag,
    input  logic                  flush,
    input  logic                  cpl_valid,
    input  logic [TAG_W-1:0]      cpl_tag,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  free,
    output logic                  cpl_live,
    output logic                  cpl_discard,
    output logic                  rs1_match,
    output logic                  rs2_match,
    output logic                  rd_match
);

    sb_state_e             state_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  commit_hit;
    logic                  cpl_hit;
    logic                  held;
    logic                  busy;

    assign commit_hit = commit_valid && (commit_tag == TAG_W'(IDX));
    assign cpl_hit    = cpl_valid && (cpl_tag == TAG_W'(IDX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SB_FREE;
            rd_q    <= '0;
        end else begin
            state_q <= sb_next_state(state_q, alloc, commit_hit, flush, cpl_hit);
            if (alloc && state_q == SB_FREE)
                rd_q <= alloc_rd;
        end
    end

    assign free        = (state_q == SB_FREE);
    assign cpl_live    = cpl_hit && !free;
    assign cpl_discard = cpl_hit && ((state_q == SB_KILL) || (state_q == SB_PEND && flush));
    assign held        = ((state_q == SB_PEND) || (state_q == SB_CMT)) && (rd_q != '0);

`ifdef HAZARD_SB_CPL_BYPASS_EN
    // Result is on the WB forward path this cycle, so release the hazard early.
    assign busy = held && !(cpl_live && !cpl_discard);
`else
    assign busy = held;
`endif

    assign rs1_match = busy && (rs1_addr == rd_q);
    assign rs2_match = busy && (rs2_addr == rd_q);
    assign rd_match  = busy && (rd_addr == rd_q);

endmodule

// File: rtl/hazard_scoreboard.sv
// Scoreboard for out-of-order completing long-latency producers: tag
// allocation, RAW/WAW/capacity stalls and flush-aware completion discard.
// Optional same-cycle busy release: HAZARD_SB_CPL_BYPASS_EN.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned TAG_W       = $clog2(MAX_PENDING),
    parameter int unsigned CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0] id_rd_addr_i,
    input  logic                  id_is_rd_write_i,
    input  logic                  id_is_long_op_i,
    input  logic                  id_fire_i,
    output logic [TAG_W-1:0]      issue_tag_o,
    input  logic                  commit_valid_i,
    input  logic [TAG_W-1:0]      commit_tag_i,
    input  logic                  flush_i,
    input  logic                  cpl_valid_i,
    input  logic [TAG_W-1:0]      cpl_tag_i,
    output logic                  cpl_discard_o,
    output logic                  id_stall_o,
    output logic                  stall_raw_o,
    output logic                  stall_waw_o,
    output logic                  stall_full_o,
    output logic [CNT_W-1:0]      pending_cnt_o,
    output logic                  err_o
);

    logic [MAX_PENDING-1:0] ent_free, ent_live, ent_discard, ent_alloc;
    logic [MAX_PENDING-1:0] m_rs1, m_rs2, m_rd;
    logic                   any_free, alloc, cpl_err, dec;
    logic [REG_ADDR_W-1:0]  alloc_rd;

    assign any_free = |ent_free;

    always_comb begin
        issue_tag_o = '0;
        for (int unsigned i = MAX_PENDING; i > 0; i--)
            if (ent_free[i-1]) issue_tag_o = TAG_W'(i - 1);
    end

    assign alloc    = id_fire_i && id_is_long_op_i && !flush_i && any_free;
    assign alloc_rd = id_is_rd_write_i ? id_rd_addr_i : '0;

    for (genvar g = 0; g < MAX_PENDING; g++) begin : g_ent
        assign ent_alloc[g] = alloc && (issue_tag_o == TAG_W'(g));

        hazard_sb_entry #(
            .REG_ADDR_W (REG_ADDR_W),
            .TAG_W      (TAG_W),
            .IDX        (g)
        ) u_entry (
            .clk          (clk_i),
            .rst_n        (rst_ni),
            .alloc        (ent_alloc[g]),
            .alloc_rd     (alloc_rd),
            .commit_valid (commit_valid_i),
            .commit_tag   (commit_tag_i),
            .flush        (flush_i),
            .cpl_valid    (cpl_valid_i),
            .cpl_tag      (cpl_tag_i),
            .rs1_addr     (id_rs1_addr_i),
            .rs2_addr     (id_rs2_addr_i),
            .rd_addr      (id_rd_addr_i),
            .free         (ent_free[g]),
            .cpl_live     (ent_live[g]),
            .cpl_discard  (ent_discard[g]),
            .rs1_match    (m_rs1[g]),
            .rs2_match    (m_rs2[g]),
            .rd_match     (m_rd[g])
        );
    end

    // A completion that hits no live entry (FREE or out-of-range tag) is an error.
    assign dec           = cpl_valid_i && (|ent_live);
    assign cpl_err       = cpl_valid_i && !(|ent_live);
    assign cpl_discard_o = (|ent_discard) || cpl_err;

    assign stall_raw_o  = id_valid_i && (((id_rs1_addr_i != '0) && (|m_rs1)) ||
                                         ((id_rs2_addr_i != '0) && (|m_rs2)));
    assign stall_waw_o  = id_valid_i && id_is_rd_write_i && (id_rd_addr_i != '0) && (|m_rd);
    assign stall_full_o = id_valid_i && id_is_long_op_i && !any_free;
    assign id_stall_o   = stall_raw_o || stall_waw_o || stall_full_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_cnt_o <= '0;
            err_o         <= 1'b0;
        end else begin
            if (alloc && !dec)
                pending_cnt_o <= pending_cnt_o + CNT_W'(1);
            else if (dec && !alloc)
                pending_cnt_o <= pending_cnt_o - CNT_W'(1);
            if (cpl_err)
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard; expectations follow
// HAZARD_SB_CPL_BYPASS_EN for the stall-release cycle.
module tb_hazard_scoreboard;

    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned MAX_PENDING = 4;
    localparam int unsigned TAG_W       = 2;
    localparam int unsigned CNT_W       = 3;

`ifdef HAZARD_SB_CPL_BYPASS_EN
    localparam logic RAW_IN_CPL_CYCLE = 1'b0;
`else
    localparam logic RAW_IN_CPL_CYCLE = 1'b1;
`endif

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic                  id_valid_i, id_is_rd_write_i, id_is_long_op_i, id_fire_i;
    logic [REG_ADDR_W-1:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic [TAG_W-1:0]      issue_tag_o, commit_tag_i, cpl_tag_i;
    logic                  commit_valid_i, flush_i, cpl_valid_i;
    logic                  cpl_discard_o, id_stall_o, stall_raw_o, stall_waw_o, stall_full_o;
    logic [CNT_W-1:0]      pending_cnt_o;
    logic                  err_o;

    hazard_scoreboard #(
        .REG_ADDR_W  (REG_ADDR_W),
        .MAX_PENDING (MAX_PENDING)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .id_valid_i       (id_valid_i),
        .id_rs1_addr_i    (id_rs1_addr_i),
        .id_rs2_addr_i    (id_rs2_addr_i),
        .id_rd_addr_i     (id_rd_addr_i),
        .id_is_rd_write_i (id_is_rd_write_i),
        .id_is_long_op_i  (id_is_long_op_i),
        .id_fire_i        (id_fire_i),
        .issue_tag_o      (issue_tag_o),
        .commit_valid_i   (commit_valid_i),
        .commit_tag_i     (commit_tag_i),
        .flush_i          (flush_i),
        .cpl_valid_i      (cpl_valid_i),
        .cpl_tag_i        (cpl_tag_i),
        .cpl_discard_o    (cpl_discard_o),
        .id_stall_o       (id_stall_o),
        .stall_raw_o      (stall_raw_o),
        .stall_waw_o      (stall_waw_o),
        .stall_full_o     (stall_full_o),
        .pending_cnt_o    (pending_cnt_o),
        .err_o            (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string name, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL queue_underflow observed %0d expected none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %0d expected %0d", e.name, obs, e.val);
            end
        end
    endtask

    task automatic clear_in();
        id_valid_i = 0; id_rs1_addr_i = '0; id_rs2_addr_i = '0; id_rd_addr_i = '0;
        id_is_rd_write_i = 0; id_is_long_op_i = 0; id_fire_i = 0;
        commit_valid_i = 0; commit_tag_i = '0; flush_i = 0;
        cpl_valid_i = 0; cpl_tag_i = '0;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic wr, input logic lng, input logic fire);
        id_valid_i = v; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2; id_rd_addr_i = rd;
        id_is_rd_write_i = wr; id_is_long_op_i = lng; id_fire_i = fire;
    endtask

    task automatic drive_cpl(input logic v, input logic [1:0] tag);
        cpl_valid_i = v; cpl_tag_i = tag;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_in();
        rst_ni = 0;
        #3;
        push("rst_pending", 0); push("rst_err", 0); push("rst_stall", 0);
        push("rst_discard", 0); push("rst_issue_tag", 0);
        pop_check(pending_cnt_o); pop_check(err_o); pop_check(id_stall_o);
        pop_check(cpl_discard_o); pop_check(issue_tag_o);
        next_cycle();
        rst_ni = 1;

        // RAW on a load result, release timing around completion
        drive_id(1, 0, 0, 5, 1, 1, 1);
        push("ld_issue_tag", 0); push("ld_full", 0); push("ld_raw", 0);
        @(negedge clk);
        pop_check(issue_tag_o); pop_check(stall_full_o); pop_check(stall_raw_o);
        next_cycle();
        drive_id(1, 5, 0, 6, 1, 0, 0);
        push("raw_set", 1); push("raw_id_stall", 1); push("raw_pending", 1); push("raw_issue_tag", 1);
        @(negedge clk);
        pop_check(stall_raw_o); pop_check(id_stall_o); pop_check(pending_cnt_o); pop_check(issue_tag_o);
        next_cycle();
        drive_id(1, 0, 0, 5, 1, 0, 0);
        push("waw_set", 1); push("waw_no_raw", 0);
        @(negedge clk);
        pop_check(stall_waw_o); pop_check(stall_raw_o);
        next_cycle();
        drive_id(1, 5, 0, 6, 1, 0, 0);
        drive_cpl(1, 0);
        push("raw_cpl_cycle", 32'(RAW_IN_CPL_CYCLE)); push("cpl0_discard", 0);
        @(negedge clk);
        pop_check(stall_raw_o); pop_check(cpl_discard_o);
        next_cycle();
        drive_cpl(0, 0);
        push("raw_after_cpl", 0); push("pending_after_cpl", 0);
        @(negedge clk);
        pop_check(stall_raw_o); pop_check(pending_cnt_o);
        next_cycle();
        clear_in();

        // Capacity: four long ops, fifth stalls, freed tag is reused
        for (int i = 0; i < 4; i++) begin
            drive_id(1, 0, 0, 5'(i + 1), 1, 1, 1);
            push("fill_issue_tag", 32'(i));
            @(negedge clk);
            pop_check(issue_tag_o);
            next_cycle();
        end
        drive_id(1, 0, 0, 9, 1, 1, 0);
        push("full_pending", 4); push("full_stall", 1); push("full_id_stall", 1); push("full_issue_tag", 0);
        @(negedge clk);
        pop_check(pending_cnt_o); pop_check(stall_full_o); pop_check(id_stall_o); pop_check(issue_tag_o);
        next_cycle();
        clear_in();
        drive_cpl(1, 2);
        push("cpl2_discard", 0);
        @(negedge clk);
        pop_check(cpl_discard_o);
        next_cycle();
        drive_cpl(0, 0);
        drive_id(1, 0, 0, 7, 1, 1, 1);
        push("reuse_issue_tag", 2); push("reuse_full", 0); push("reuse_pending", 3);
        @(negedge clk);
        pop_check(issue_tag_o); pop_check(stall_full_o); pop_check(pending_cnt_o);
        next_cycle();
        clear_in();
        push("refill_pending", 4);
        @(negedge clk);
        pop_check(pending_cnt_o);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive_cpl(1, 2'(i));
            push("drain_discard", 0);
            @(negedge clk);
            pop_check(cpl_discard_o);
            next_cycle();
        end
        clear_in();
        push("drain_pending", 0);
        @(negedge clk);
        pop_check(pending_cnt_o);
        next_cycle();

        // Flush kills PEND, spares CMT; flush blocks allocation
        drive_id(1, 0, 0, 8, 1, 1, 1);
        next_cycle();
        drive_id(1, 0, 0, 9, 1, 1, 1);
        push("fl_issue_tag", 1);
        @(negedge clk);
        pop_check(issue_tag_o);
        next_cycle();
        clear_in();
        commit_valid_i = 1; commit_tag_i = 1;
        next_cycle();
        clear_in();
        flush_i = 1;
        drive_id(1, 0, 0, 10, 1, 1, 1);
        next_cycle();
        clear_in();
        drive_id(1, 8, 0, 0, 0, 0, 0);
        push("fl_pending", 2); push("fl_kill_no_raw", 0);
        @(negedge clk);
        pop_check(pending_cnt_o); pop_check(stall_raw_o);
        next_cycle();
        drive_id(1, 0, 9, 0, 0, 0, 0);
        push("fl_cmt_raw", 1);
        @(negedge clk);
        pop_check(stall_raw_o);
        next_cycle();
        clear_in();
        drive_cpl(1, 0);
        push("kill_discard", 1);
        @(negedge clk);
        pop_check(cpl_discard_o);
        next_cycle();
        drive_cpl(1, 1);
        push("cmt_discard", 0);
        @(negedge clk);
        pop_check(cpl_discard_o);
        next_cycle();
        clear_in();
        push("fl_done_pending", 0); push("fl_done_err", 0);
        @(negedge clk);
        pop_check(pending_cnt_o); pop_check(err_o);
        next_cycle();

        // Commit and flush on tag 3 in the same cycle
        for (int i = 0; i < 4; i++) begin
            drive_id(1, 0, 0, 5'(10 + i), 1, 1, 1);
            next_cycle();
        end
        clear_in();
        commit_valid_i = 1; commit_tag_i = 3; flush_i = 1;
        next_cycle();
        clear_in();
        drive_id(1, 13, 0, 0, 0, 0, 0);
        push("cf_tag3_raw", 1);
        @(negedge clk);
        pop_check(stall_raw_o);
        next_cycle();
        drive_id(1, 10, 0, 10, 1, 0, 0);
        push("cf_tag0_raw", 0); push("cf_tag0_waw", 0);
        @(negedge clk);
        pop_check(stall_raw_o); pop_check(stall_waw_o);
        next_cycle();
        clear_in();
        for (int i = 0; i < 4; i++) begin
            drive_cpl(1, 2'(i));
            push("cf_discard", (i == 3) ? 0 : 1);
            @(negedge clk);
            pop_check(cpl_discard_o);
            next_cycle();
        end
        clear_in();
        drive_id(1, 0, 0, 14, 1, 1, 1);
        next_cycle();
        clear_in();
        drive_cpl(1, 0); flush_i = 1;
        push("cpl_flush_discard", 1);
        @(negedge clk);
        pop_check(cpl_discard_o);
        next_cycle();
        clear_in();
        push("cpl_flush_pending", 0); push("cpl_flush_err", 0);
        @(negedge clk);
        pop_check(pending_cnt_o); pop_check(err_o);
        next_cycle();

        // Completion to a FREE tag
        drive_cpl(1, 1);
        push("free_cpl_discard", 1); push("free_cpl_err_pre", 0);
        @(negedge clk);
        pop_check(cpl_discard_o); pop_check(err_o);
        next_cycle();
        clear_in();
        push("free_cpl_err", 1); push("free_cpl_pending", 0);
        @(negedge clk);
        pop_check(err_o); pop_check(pending_cnt_o);
        next_cycle();
        next_cycle();
        push("err_sticky", 1);
        @(negedge clk);
        pop_check(err_o);
        next_cycle();

        // x0 destinations never block; async reset mid-run
        drive_id(1, 0, 0, 0, 1, 1, 1);
        next_cycle();
        drive_id(1, 7, 0, 7, 0, 1, 1);
        push("x0_pending", 1); push("x0_issue_tag", 1);
        @(negedge clk);
        pop_check(pending_cnt_o); pop_check(issue_tag_o);
        next_cycle();
        drive_id(1, 0, 7, 7, 1, 0, 0);
        push("nowr_raw", 0); push("nowr_waw", 0); push("nowr_pending", 2);
        @(negedge clk);
        pop_check(stall_raw_o); pop_check(stall_waw_o); pop_check(pending_cnt_o);
        next_cycle();
        drive_id(1, 0, 0, 3, 1, 0, 0);
        push("x0_read_raw", 0);
        @(negedge clk);
        pop_check(stall_raw_o);
        next_cycle();
        drive_id(1, 7, 0, 0, 0, 0, 0);
        rst_ni = 0;
        #1;
        push("arst_pending", 0); push("arst_err", 0); push("arst_stall", 0);
        pop_check(pending_cnt_o); pop_check(err_o); pop_check(id_stall_o);
        next_cycle();
        rst_ni = 1;
        clear_in();
        drive_cpl(1, 0);
        push("post_rst_cpl_discard", 1);
        @(negedge clk);
        pop_check(cpl_discard_o);
        next_cycle();
        clear_in();
        push("post_rst_err", 1); push("post_rst_pending", 0);
        @(negedge clk);
        pop_check(err_o); pop_check(pending_cnt_o);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_leftover observed %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
